// File: rtl/io_in_conditioner.sv
// Pad input conditioning: two-flop synchronisation of the whole pad bus, then
// counter-based debouncing with rising-edge pulses on a contiguous group of button pads.
module io_in_conditioner #(
  parameter int unsigned PADS      = 38,
  parameter int unsigned DEB_PINS  = 3,
  parameter int unsigned DEB_BASE  = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEB_LIMIT = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PADS-1:0]     io_in,
  input  logic                flush,
  output logic [PADS-1:0]     io_sync,
  output logic [DEB_PINS-1:0] btn_level,
  output logic [DEB_PINS-1:0] btn_rise
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_LIMIT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [PADS-1:0]     s1_q;
  logic [PADS-1:0]     s2_q;
  logic [DEB_PINS-1:0] btn_raw;

  logic [DEB_PINS-1:0] lvl_q;
  logic [DEB_PINS-1:0] lvl_d;
  logic [DEB_PINS-1:0] rise_q;
  logic [DEB_PINS-1:0] rise_d;
  logic [CNT_W-1:0]    cnt_q [DEB_PINS];
  logic [CNT_W-1:0]    cnt_d [DEB_PINS];

  // Flush drops the sync stages too, so a new project never sees the old pads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (flush) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= io_in;
      s2_q <= s1_q;
    end
  end

  assign io_sync = s2_q;
  assign btn_raw = s2_q[DEB_BASE +: DEB_PINS];

  always_comb begin
    lvl_d  = lvl_q;
    rise_d = '0;
    for (int i = 0; i < int'(DEB_PINS); i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (flush) begin
      lvl_d = '0;
      for (int i = 0; i < int'(DEB_PINS); i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < int'(DEB_PINS); i++) begin
        if (btn_raw[i] == lvl_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          // Accept the new level; only a 0->1 acceptance pulses.
          lvl_d[i]  = btn_raw[i];
          rise_d[i] = btn_raw[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q  <= '0;
      rise_q <= '0;
      for (int i = 0; i < int'(DEB_PINS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      for (int i = 0; i < int'(DEB_PINS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level = lvl_q;
  assign btn_rise  = rise_q;

endmodule

// File: tb/tb_io_in_conditioner.sv
// Randomised and directed bench for io_in_conditioner against a sliding-window
// reference model of synchroniser and debouncer behaviour.
module tb_io_in_conditioner;

  localparam int PADS  = 38;
  localparam int PINS  = 3;
  localparam int BASE  = 2;
  localparam int LIMIT = 4;
  localparam logic [PADS-1:0] ALL1 = {PADS{1'b1}};

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [PADS-1:0] io_in = '0;
  logic            flush = 1'b0;
  logic [PADS-1:0] io_sync;
  logic [PINS-1:0] btn_level;
  logic [PINS-1:0] btn_rise;

  int total = 0;
  int bad = 0;
  int rise_cnt = 0;
  bit cmp_en = 1'b0;

  io_in_conditioner #(
    .PADS     (PADS),
    .DEB_PINS (PINS),
    .DEB_BASE (BASE),
    .CNT_W    (16),
    .DEB_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_in    (io_in),
    .flush    (flush),
    .io_sync  (io_sync),
    .btn_level(btn_level),
    .btn_rise (btn_rise)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: io_sync is io_in delayed by two edges; a button accepts a new level
  // once the last LIMIT synchronised samples all disagree with its current level.
  logic [PADS-1:0] m_s1 = '0;
  logic [PADS-1:0] m_s2 = '0;
  logic [PINS-1:0] m_lvl = '0;
  logic [PINS-1:0] m_rise = '0;
  logic [PADS-1:0] hist[$];

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      m_s1 = '0;
      m_s2 = '0;
      m_lvl = '0;
      m_rise = '0;
      hist.delete();
    end else begin
      logic [PADS-1:0] smp;
      m_rise = '0;
      hist.push_back(m_s2);
      while (hist.size() > LIMIT) void'(hist.pop_front());
      for (int i = 0; i < PINS; i++) begin
        bit all_differ;
        all_differ = (hist.size() == LIMIT);
        for (int k = 0; k < hist.size(); k++) begin
          smp = hist[k];
          if (smp[BASE+i] == m_lvl[i]) all_differ = 1'b0;
        end
        if (all_differ) begin
          m_lvl[i]  = ~m_lvl[i];
          m_rise[i] = m_lvl[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = io_in;
    end
  end

  always @(negedge clk) begin
    if (btn_rise != '0) rise_cnt++;
    if (cmp_en) begin
      check("model_io_sync", 64'(io_sync), 64'(m_s2));
      check("model_level", 64'(btn_level), 64'(m_lvl));
      check("model_rise", 64'(btn_rise), 64'(m_rise));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PINS-1:0] btn_state;
    int rc;
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    tick(2);
    check("reset_sync", 64'(io_sync), 64'd0);
    reset = 1'b0;
    io_in = ALL1;
    tick(10);
    check("ones_level", 64'(btn_level), 64'h7);

    // Reset mid-cycle with all pads high.
    #3 reset = 1'b1;
    #1;
    check("rst_io_sync", 64'(io_sync), 64'd0);
    check("rst_level", 64'(btn_level), 64'd0);
    check("rst_rise", 64'(btn_rise), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1);
    check("rel_edge1", 64'(io_sync), 64'd0);
    tick(1);
    check("rel_edge2", 64'(io_sync), 64'(ALL1));

    // Sync latency on pad 20.
    io_in = '0;
    tick(10);
    io_in[20] = 1'b1;
    tick(1);
    check("sync_e1", 64'(io_sync[20]), 64'd0);
    tick(1);
    check("sync_e2", 64'(io_sync[20]), 64'd1);

    // Clean press and release on pad 3.
    io_in = '0;
    tick(10);
    io_in[3] = 1'b1;
    tick(5);
    check("press_e5_lvl", 64'(btn_level), 64'd0);
    tick(1);
    check("press_e6_lvl", 64'(btn_level), 64'b010);
    check("press_e6_rise", 64'(btn_rise), 64'b010);
    tick(1);
    check("press_e7_rise", 64'(btn_rise), 64'd0);
    io_in[3] = 1'b0;
    rc = rise_cnt;
    tick(5);
    check("rel_e5_lvl", 64'(btn_level), 64'b010);
    tick(1);
    check("rel_e6_lvl", 64'(btn_level), 64'd0);
    check("rel_no_pulse", 64'(rise_cnt), 64'(rc));

    // Glitch rejection on pad 2, then a just-long-enough press.
    tick(5);
    rc = rise_cnt;
    io_in[2] = 1'b1;
    tick(3);
    io_in[2] = 1'b0;
    tick(8);
    check("glitch_lvl", 64'(btn_level), 64'd0);
    check("glitch_no_rise", 64'(rise_cnt), 64'(rc));
    io_in[2] = 1'b1;
    tick(4);
    io_in[2] = 1'b0;
    tick(2);
    check("min_press_lvl", 64'(btn_level), 64'b001);
    check("min_press_rise", 64'(btn_rise), 64'b001);
    tick(10);

    // Two buttons together.
    io_in[2] = 1'b1;
    io_in[4] = 1'b1;
    tick(6);
    check("simul_rise", 64'(btn_rise), 64'b101);
    tick(1);
    check("simul_rise_off", 64'(btn_rise), 64'd0);
    check("simul_lvl", 64'(btn_level), 64'b101);

    // Flush mid-count on pad 4.
    io_in = '0;
    tick(10);
    io_in[4] = 1'b1;
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_sync", 64'(io_sync), 64'd0);
    check("flush_lvl", 64'(btn_level), 64'd0);
    check("flush_rise", 64'(btn_rise), 64'd0);
    tick(5);
    check("flush_e9_lvl", 64'(btn_level), 64'd0);
    tick(1);
    check("flush_e10_lvl", 64'(btn_level), 64'b100);
    check("flush_e10_rise", 64'(btn_rise), 64'b100);

    // Random traffic with slowly toggling buttons, occasional flush and reset.
    btn_state = '0;
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      for (int i = 0; i < PINS; i++) begin
        if ($urandom_range(0, 5) == 0) btn_state[i] = ~btn_state[i];
      end
      r[BASE +: PINS] = btn_state;
      io_in = r[PADS-1:0];
      flush = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 1'b0;
    flush = 1'b0;
    tick(2);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
